servo_ramp_ctrl: RTL and testbench

- Upstream command stage for the servo PWM generator. Accepts 8-bit position commands over a valid/ready handshake and maps each one to a duty count.
- Slews the applied duty toward the commanded value by a bounded step once per PWM frame. Drives the generator's Enable, duty (12 bit) and period (20 bit) inputs.
- Duty changes only at frame boundaries, so the generator never sees a mid-frame update.

---
 rtl/servo_ramp_ctrl.sv | 106 ++++++++++
 tb/tb_servo_ramp_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_ramp_ctrl.sv
// Servo command stage: maps 8-bit positions to duty counts and slews the applied
// duty toward the target by at most STEP per PWM frame, updating only at frame ends.
module servo_ramp_ctrl #(
    parameter int PERIOD   = 20000,
    parameter int DUTY_MIN = 1000,
    parameter int DUTY_MAX = 2000,
    parameter int STEP     = 10,
    parameter int HOME_POS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  cmd_pos,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        pwm_enable,
    output logic [11:0] dutty,
    output logic [19:0] period,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE and does not depend on cmd_valid.

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_MOVE = 2'd2;

    localparam int          SPAN     = DUTY_MAX - DUTY_MIN;
    localparam logic [19:0] PERIOD_W = 20'(PERIOD);
    localparam logic [11:0] STEP_W   = 12'(STEP);

    function automatic logic [11:0] f_map(input logic [7:0] pos);
        logic [19:0] prod;
        prod = 20'(pos) * 20'(SPAN);
        return 12'(DUTY_MIN) + 12'(prod >> 8);
    endfunction

    localparam logic [11:0] HOME_DUTY = f_map(8'(HOME_POS));

    logic [1:0]  r_state;
    logic [11:0] r_cur;
    logic [11:0] r_tgt;
    logic [19:0] r_fc;
    logic        r_done;

    logic        w_fb;
    logic [11:0] w_diff;
    logic [11:0] w_map;

    assign w_fb   = en && (r_fc == PERIOD_W);
    assign w_diff = (r_cur >= r_tgt) ? (r_cur - r_tgt) : (r_tgt - r_cur);
    assign w_map  = f_map(cmd_pos);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OFF;
            r_cur   <= HOME_DUTY;
            r_tgt   <= HOME_DUTY;
            r_fc    <= '0;
            r_done  <= 1'b0;
        end else if (!en) begin
            // Disable wins over everything: the pending move is dropped, cur/tgt kept.
            r_state <= S_OFF;
            r_fc    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_fc   <= (r_fc < PERIOD_W) ? r_fc + 20'd1 : '0;
            r_done <= 1'b0;
            case (r_state)
                S_OFF: r_state <= S_IDLE;
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_tgt   <= w_map;
                        r_state <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (w_fb) begin
                        if (w_diff <= STEP_W) begin
                            r_cur   <= r_tgt;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (r_tgt > r_cur) begin
                            r_cur <= r_cur + STEP_W;
                        end else begin
                            r_cur <= r_cur - STEP_W;
                        end
                    end
                end
                default: r_state <= S_OFF;
            endcase
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign pwm_enable = (r_state != S_OFF);
    assign busy       = (r_state == S_MOVE);
    assign done       = r_done;
    assign dutty      = r_cur;
    assign period     = PERIOD_W;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Bench for servo_ramp_ctrl: directed scenarios plus random moves, with a scoreboard
// of expected duty steps and move completions checked by an independent monitor.
module tb_servo_ramp_ctrl;

  localparam int PERIOD = 99;
  localparam int STEP   = 50;
  localparam int DMIN   = 1000;
  localparam int DMAX   = 2000;
  localparam int HOME   = 1500;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  cmd_pos;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        pwm_enable;
  logic [11:0] dutty;
  logic [19:0] period;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  servo_ramp_ctrl #(
    .PERIOD(PERIOD), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .STEP(STEP), .HOME_POS(128)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cmd_pos(cmd_pos), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .pwm_enable(pwm_enable), .dutty(dutty), .period(period),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_q[$];   // expected duty values, one per frame step
  logic [11:0] done_q[$];  // expected final duty of each completed move
  int          m_cur;
  int          tfc;
  bit          mon_on;
  logic [11:0] prev_dutty;
  logic        prev_done;
  logic [11:0] mon_exp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_map(input int pos);
    return DMIN + ((pos * (DMAX - DMIN)) / 256);
  endfunction

  // frame position model: counts enabled cycles modulo PERIOD+1
  initial begin
    tfc = 0;
    forever begin
      @(posedge clk);
      if (rst || !en) tfc = 0;
      else tfc = (tfc == PERIOD) ? 0 : tfc + 1;
    end
  end

  // monitor / scoreboard
  initial begin
    prev_dutty = '0;
    prev_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (dutty !== prev_dutty) begin
          if (exp_q.size() == 0) begin
            check("dutty_unexpected_change", int'(dutty), int'(prev_dutty));
          end else begin
            mon_exp = exp_q.pop_front();
            check("dutty_step", int'(dutty), int'(mon_exp));
            check("dutty_step_frame_edge", tfc, 0);
          end
        end
        if (done === 1'b1) begin
          check("done_width", int'(prev_done), 0);
          if (done_q.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            mon_exp = done_q.pop_front();
            check("done_final_duty", int'(dutty), int'(mon_exp));
            check("done_frame_edge", tfc, 0);
          end
        end
      end
      prev_dutty = dutty;
      prev_done  = done;
    end
  end

  // driver: one command, optionally followed by a strobe that must be ignored
  task automatic send_cmd(input int pos, input bit extra, input int pos2);
    int n;
    int c;
    int t;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_send", int'(cmd_ready), 1);
    t = ref_map(pos);
    c = m_cur;
    while (c != t) begin
      if ((t > c ? t - c : c - t) <= STEP) c = t;
      else if (t > c) c = c + STEP;
      else c = c - STEP;
      exp_q.push_back(12'(c));
    end
    done_q.push_back(12'(t));
    m_cur = t;
    cmd_pos   = 8'(pos);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    check("cmd_ready_in_move", int'(cmd_ready), 0);
    check("state_move", int'(dbg_state), 2);
    if (extra) begin
      cmd_pos   = 8'(pos2);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_moves(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, exp_q.size() + done_q.size(), 0);
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    check({name, "_ready_after"}, int'(cmd_ready), 1);
    check({name, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p;
    rst = 1'b1; en = 1'b0; cmd_valid = 1'b0; cmd_pos = '0;
    mon_on = 1'b0; m_cur = HOME;
    repeat (3) @(negedge clk);
    check("period_in_reset", int'(period), PERIOD);
    rst = 1'b0;
    @(negedge clk);
    check("rst_dutty", int'(dutty), HOME);
    check("rst_pwm_enable", int'(pwm_enable), 0);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dbg_state), 0);

    en = 1'b1;
    @(negedge clk);
    check("en_pwm_enable", int'(pwm_enable), 1);
    check("en_cmd_ready", int'(cmd_ready), 1);
    check("en_busy", int'(busy), 0);
    check("en_dutty", int'(dutty), HOME);
    check("en_period", int'(period), PERIOD);
    check("en_state", int'(dbg_state), 1);
    mon_on = 1'b1;

    send_cmd(255, 1'b0, 0);
    wait_moves("move_to_max");
    check("max_dutty", int'(dutty), 1996);
    send_cmd(0, 1'b0, 0);
    wait_moves("move_to_min");
    check("min_dutty", int'(dutty), 1000);
    send_cmd(128, 1'b0, 0);
    wait_moves("move_to_mid");
    send_cmd(128, 1'b1, 255);
    wait_moves("move_same");
    check("same_dutty_kept", int'(dutty), 1500);

    // drop enable mid-move at 1700
    send_cmd(0, 1'b0, 0);
    wait_moves("move_back_min");
    send_cmd(255, 1'b0, 0);
    n = 0;
    while (dutty !== 12'd1700 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach_1700", int'(dutty), 1700);
    @(negedge clk);
    en = 1'b0;
    exp_q.delete();
    done_q.delete();
    m_cur = 1700;
    @(negedge clk);
    check("endrop_pwm_enable", int'(pwm_enable), 0);
    check("endrop_busy", int'(busy), 0);
    check("endrop_done", int'(done), 0);
    check("endrop_state", int'(dbg_state), 0);
    check("endrop_dutty", int'(dutty), 1700);
    repeat (5) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("reen_state", int'(dbg_state), 1);
    check("reen_cmd_ready", int'(cmd_ready), 1);
    check("reen_dutty", int'(dutty), 1700);

    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(0, 255);
      send_cmd(p, 1'($urandom_range(0, 1)), $urandom_range(0, 255));
      wait_moves("rand_move");
    end

    // reset asserted mid-move with en and cmd_valid high
    send_cmd((m_cur > 1500) ? 0 : 255, 1'b0, 0);
    repeat (150) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    mon_on = 1'b0;
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_pos = 8'($urandom_range(0, 255));
    @(negedge clk);
    check("midrst_dutty", int'(dutty), HOME);
    check("midrst_state", int'(dbg_state), 0);
    check("midrst_pwm_enable", int'(pwm_enable), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_cmd_ready", int'(cmd_ready), 0);
    check("midrst_period", int'(period), PERIOD);
    rst = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
